branch_cmp_unit: RTL and testbench

// - Multi-cycle RV32I branch resolver; drives the shared 32-bit ALU, consuming result_y and carry.
// - Sits between decode and PC select. Accepts one branch per valid/ready handshake.
// - Issues SUB (rs1-rs2) for condition flags, then ADD (pc+imm) for target; returns taken/target.

---
 rtl/branch_cmp_unit.sv | 104 ++++++++++
 tb/tb_branch_cmp_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit: multi-cycle RV32I branch resolver sharing an external ALU (SUB for flags, ADD for target).
// Optional target-misalignment flag enabled by defining BRANCH_MISALIGN_EN.
module branch_cmp_unit #(
  parameter int          XLEN   = 32,
  parameter logic [3:0]  OP_ADD = 4'h0,
  parameter logic [3:0]  OP_SUB = 4'h1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  output logic [XLEN-1:0] alu_operand_a_out,
  output logic [XLEN-1:0] alu_operand_b_out,
  output logic [3:0]      alu_operation_out,
  input  logic [XLEN-1:0] alu_result_y_in,
  input  logic            alu_carry_in,
  output logic            resp_valid_out,
  input  logic            resp_ready_in,
  output logic            taken_out,
  output logic [XLEN-1:0] target_out,
  output logic            invalid_out,
  output logic            misaligned_out
);
  typedef enum logic [1:0] {IDLE, CMP, TGT, RESP} state_t;
  state_t          state_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q, diff_q, target_q;
  logic            c_q, taken_q, invalid_q;
  logic            eq, ltu, ovf, lt, taken_d, invalid_d;
  always_comb begin
    alu_operand_a_out = state_q == CMP ? rs1_q : state_q == TGT ? pc_q : '0;
    alu_operand_b_out = state_q == CMP ? rs2_q : state_q == TGT ? imm_q : '0;
    alu_operation_out = state_q == CMP ? OP_SUB : OP_ADD;
    eq  = diff_q == '0;
    ltu = ~c_q;
    ovf = (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]) & (diff_q[XLEN-1] ^ rs1_q[XLEN-1]);
    lt  = diff_q[XLEN-1] ^ ovf;
    taken_d = funct3_q == 3'b000 ? eq  :
              funct3_q == 3'b001 ? ~eq :
              funct3_q == 3'b100 ? lt  :
              funct3_q == 3'b101 ? ~lt :
              funct3_q == 3'b110 ? ltu :
              funct3_q == 3'b111 ? ~ltu : 1'b0;
    invalid_d = funct3_q[2:1] == 2'b01;
  end
  assign req_ready_out  = state_q == IDLE;
  assign resp_valid_out = state_q == RESP;
  assign taken_out      = taken_q;
  assign target_out     = target_q;
  assign invalid_out    = invalid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      diff_q    <= '0;
      c_q       <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      invalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_in) begin
          funct3_q <= funct3_in;
          rs1_q    <= rs1_in;
          rs2_q    <= rs2_in;
          pc_q     <= pc_in;
          imm_q    <= imm_in;
          state_q  <= CMP;
        end
        CMP: begin
          diff_q  <= alu_result_y_in;
          c_q     <= alu_carry_in;
          state_q <= TGT;
        end
        TGT: begin
          target_q  <= alu_result_y_in;
          taken_q   <= taken_d;
          invalid_q <= invalid_d;
          state_q   <= RESP;
        end
        default: if (resp_ready_in) state_q <= IDLE;
      endcase
    end
  end
`ifdef BRANCH_MISALIGN_EN
  logic misaligned_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else if (state_q == TGT) misaligned_q <= taken_d && (alu_result_y_in[1:0] != 2'b00);
  end
  assign misaligned_out = misaligned_q;
`else
  assign misaligned_out = 1'b0;
`endif
endmodule

// File: tb/tb_branch_cmp_unit.sv
// tb_branch_cmp_unit: randomized and directed checks of branch_cmp_unit against a behavioural branch model.
module tb_branch_cmp_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_in = 1'b0, req_ready_out;
  logic [2:0]  funct3_in = '0;
  logic [31:0] rs1_in = '0, rs2_in = '0, pc_in = '0, imm_in = '0;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        alu_c;
  logic        resp_valid_out, resp_ready_in = 1'b0;
  logic        taken_out, invalid_out, misaligned_out;
  logic [31:0] target_out;
  int          checks = 0, errors = 0;
  logic        got_taken, got_invalid, got_mis;
  logic [31:0] got_target;

  branch_cmp_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .funct3_in(funct3_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .pc_in(pc_in), .imm_in(imm_in),
    .alu_operand_a_out(alu_a), .alu_operand_b_out(alu_b), .alu_operation_out(alu_op),
    .alu_result_y_in(alu_y), .alu_carry_in(alu_c),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .taken_out(taken_out), .target_out(target_out),
    .invalid_out(invalid_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  // Shared ALU: a+b for ADD, a+~b+1 for SUB, with carry-out
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = alu_op == 4'h1 ? {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1 : {1'b0, alu_a} + {1'b0, alu_b};
    alu_y = alu_sum[31:0];
    alu_c = alu_sum[32];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_alu_idle(input string name);
    chk({name, "_alu_a"}, alu_a, 32'h0);
    chk({name, "_alu_b"}, alu_b, 32'h0);
    chk({name, "_alu_op"}, {28'h0, alu_op}, 32'h0);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic [31:0] imm, input int hold);
    logic        e_taken, e_inv, e_mis;
    logic [31:0] e_tgt;
    int          n;
    e_taken = model_taken(f, a, b);
    e_inv   = (f == 3'd2) || (f == 3'd3);
    e_tgt   = pc + imm;
`ifdef BRANCH_MISALIGN_EN
    e_mis   = e_taken && (e_tgt % 4 != 0);
`else
    e_mis   = 1'b0;
`endif
    @(negedge clk);
    n = 0;
    while (!req_ready_out && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_wait", {31'h0, req_ready_out}, 32'h1);
    chk_alu_idle("idle");
    req_valid_in = 1'b1; funct3_in = f; rs1_in = a; rs2_in = b; pc_in = pc; imm_in = imm;
    @(negedge clk);
    req_valid_in = 1'($urandom_range(0, 1));
    funct3_in = 3'($urandom); rs1_in = $urandom; rs2_in = $urandom; pc_in = $urandom; imm_in = $urandom;
    chk("cmp_ready", {31'h0, req_ready_out}, 32'h0);
    chk("cmp_valid", {31'h0, resp_valid_out}, 32'h0);
    chk("cmp_alu_a", alu_a, a);
    chk("cmp_alu_b", alu_b, b);
    chk("cmp_alu_op", {28'h0, alu_op}, 32'h1);
    @(negedge clk);
    req_valid_in = 1'b0;
    chk("tgt_valid", {31'h0, resp_valid_out}, 32'h0);
    chk("tgt_alu_a", alu_a, pc);
    chk("tgt_alu_b", alu_b, imm);
    chk("tgt_alu_op", {28'h0, alu_op}, 32'h0);
    @(negedge clk);
    got_taken = taken_out; got_target = target_out; got_invalid = invalid_out; got_mis = misaligned_out;
    for (int i = 0; i <= hold; i++) begin
      chk("resp_valid", {31'h0, resp_valid_out}, 32'h1);
      chk("resp_ready_out", {31'h0, req_ready_out}, 32'h0);
      chk("taken", {31'h0, taken_out}, {31'h0, e_taken});
      chk("target", target_out, e_tgt);
      chk("invalid", {31'h0, invalid_out}, {31'h0, e_inv});
      chk("misaligned", {31'h0, misaligned_out}, {31'h0, e_mis});
      chk_alu_idle("resp");
      if (i == hold) resp_ready_in = 1'b1;
      @(negedge clk);
    end
    resp_ready_in = 1'b0;
    chk("done_valid", {31'h0, resp_valid_out}, 32'h0);
    chk("done_ready", {31'h0, req_ready_out}, 32'h1);
  endtask

  initial begin
    #1;
    chk("rst_ready", {31'h0, req_ready_out}, 32'h1);
    chk("rst_valid", {31'h0, resp_valid_out}, 32'h0);
    chk("rst_target", target_out, 32'h0);
    chk_alu_idle("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(3'd0, 32'h5, 32'h5, 32'h100, 32'h20, 0);
    chk("lit_beq_taken", {31'h0, got_taken}, 32'h1);
    chk("lit_beq_target", got_target, 32'h120);
    run(3'd4, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8, 1);
    chk("lit_blt_taken", {31'h0, got_taken}, 32'h1);
    run(3'd6, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8, 0);
    chk("lit_bltu_taken", {31'h0, got_taken}, 32'h0);
    run(3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 32'hFFFF_FFF0, 0);
    chk("lit_bge_ovf_taken", {31'h0, got_taken}, 32'h0);
    run(3'd2, 32'h1234, 32'h1234, 32'hFFFF_FFFC, 32'h8, 5);
    chk("lit_inv_taken", {31'h0, got_taken}, 32'h0);
    chk("lit_inv_invalid", {31'h0, got_invalid}, 32'h1);
    chk("lit_inv_target", got_target, 32'h4);
    run(3'd1, 32'h1, 32'h2, 32'h100, 32'h6, 0);
    chk("lit_bne_target", got_target, 32'h106);
`ifdef BRANCH_MISALIGN_EN
    chk("lit_bne_mis", {31'h0, got_mis}, 32'h1);
`else
    chk("lit_bne_mis", {31'h0, got_mis}, 32'h0);
`endif
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a, b;
      a = $urandom_range(0, 3) == 0 ? {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'($urandom_range(0, 2))} : $urandom;
      b = $urandom_range(0, 3) == 0 ? a : ($urandom_range(0, 3) == 0 ? a ^ 32'h8000_0000 : $urandom);
      run(3'($urandom), a, b, $urandom, $urandom, $urandom_range(0, 3));
    end
    // Abort in TGT: registered results from the previous branch must clear
    run(3'd0, 32'h7, 32'h7, 32'h1000, 32'h40, 0);
    @(negedge clk);
    req_valid_in = 1'b1; funct3_in = 3'd1; rs1_in = 32'h1; rs2_in = 32'h2; pc_in = 32'h10; imm_in = 32'h2;
    @(negedge clk);
    req_valid_in = 1'b0;
    @(negedge clk);
    chk("abort_in_tgt_op", {28'h0, alu_op}, 32'h0);
    chk("abort_in_tgt_a", alu_a, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'h0, req_ready_out}, 32'h1);
    chk("abort_valid", {31'h0, resp_valid_out}, 32'h0);
    chk("abort_taken", {31'h0, taken_out}, 32'h0);
    chk("abort_target", target_out, 32'h0);
    chk("abort_invalid", {31'h0, invalid_out}, 32'h0);
    chk("abort_mis", {31'h0, misaligned_out}, 32'h0);
    chk_alu_idle("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_no_resp", {31'h0, resp_valid_out}, 32'h0);
    end
    run(3'd7, 32'h0, 32'hFFFF_FFFF, 32'h400, 32'h4, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
